// File: rtl/uio_reg_responder.sv
// rtl/uio_reg_responder.sv - strobe/ack register responder for the tile's parallel host bus
module uio_reg_responder #(
  parameter int         NREGS       = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

  localparam logic [3:0] NREGS_L = 4'(NREGS);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES:0]   settle;
  logic                   strobe_p;
  logic                   armed;
  logic [7:0]             regs [NREGS];
  logic                   cap_rw;
  logic [2:0]             cap_addr;
  logic [7:0]             cap_data;
  logic                   ack;
  logic                   busy;
  logic                   err;
  logic                   last_rw;
  logic [3:0]             wcount;

  logic       strobe_s;
  logic       start;
  logic [2:0] addr;
  logic       addr_err;
  logic [7:0] rd_val;
  logic       unused_ui;

  assign strobe_s  = sync[SYNC_STAGES-1];
  assign addr      = ui_in[4:2];
  assign addr_err  = ({1'b0, addr} >= NREGS_L);
  assign start     = ena & armed & strobe_s & ~strobe_p;
  assign unused_ui = ^ui_in[7:5];
  assign uo_out    = {wcount, last_rw, err, busy, ack};

  // Unmatched (out-of-range) addresses fall through to the 8'hFF error pattern.
  always_comb begin
    rd_val = 8'hFF;
    for (int i = 0; i < NREGS; i++) begin
      if (3'(i) == addr) rd_val = regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sync     <= '0;
      settle   <= '0;
      strobe_p <= 1'b0;
      armed    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
      cap_rw   <= 1'b0;
      cap_addr <= 3'd0;
      cap_data <= 8'h00;
      ack      <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      last_rw  <= 1'b0;
      wcount   <= 4'd0;
      uio_out  <= 8'h00;
      uio_oe   <= 8'h00;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], ui_in[0]};
      strobe_p <= strobe_s;
      settle   <= {settle[SYNC_STAGES-1:0], 1'b1};
      // A rise only counts once a genuine low has been seen with ena high,
      // so a strobe held across reset or an ena rise never starts a transfer.
      if (!ena) armed <= 1'b0;
      else if (settle[SYNC_STAGES] && !strobe_s) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            cap_rw   <= ui_in[1];
            cap_addr <= addr;
            cap_data <= uio_in;
            busy     <= 1'b1;
            err      <= addr_err;
            last_rw  <= ui_in[1];
            if (!ui_in[1]) begin
              uio_out <= rd_val;
              uio_oe  <= 8'hFF;
            end
            state <= XFER;
          end
        end
        XFER: begin
          if (cap_rw && !err) begin
            for (int i = 0; i < NREGS; i++) begin
              if (3'(i) == cap_addr) regs[i] <= cap_data;
            end
            wcount <= wcount + 4'd1;
          end
          ack   <= 1'b1;
          state <= ACK;
        end
        ACK: begin
          if (!strobe_s) begin
            ack     <= 1'b0;
            busy    <= 1'b0;
            uio_oe  <= 8'h00;
            uio_out <= 8'h00;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uio_reg_responder.sv
// tb/tb_uio_reg_responder.sv - randomized self-checking bench for uio_reg_responder
module tb_uio_reg_responder;

  localparam int NREGS = 4;
  localparam int SYNC  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] mregs [8];
  int         mcount;

  logic       x_ack;
  int         x_ack_edge;
  int         x_oe_edge;
  int         x_rel_edge;
  logic [7:0] x_rdata;
  logic       x_err;
  logic       x_rw;
  logic [7:0] x_oe;
  logic       x_held;

  always #5 clk = ~clk;

  uio_reg_responder #(.NREGS(NREGS), .SYNC_STAGES(SYNC), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uio_out(uio_out), .uio_oe(uio_oe), .uo_out(uo_out)
  );

  function automatic logic [7:0] exp_read(input logic [2:0] a);
    if (int'(a) < NREGS) return mregs[a];
    return 8'hFF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    mcount = 0;
  endtask

  task automatic model_write(input logic [2:0] a, input logic [7:0] d);
    if (int'(a) < NREGS) begin
      mregs[a] = d;
      mcount = (mcount + 1) % 16;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
  endtask

  // One full handshake; results land in the x_* variables, edges counted from the first sampling edge.
  task automatic xact(input logic rw, input logic [2:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    ui_in = {3'b000, a, rw, 1'b1};
    uio_in = d;
    x_ack = 1'b0; x_ack_edge = -1; x_oe_edge = -1; x_rel_edge = -1; x_held = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (uio_oe == 8'hFF && x_oe_edge < 0) x_oe_edge = n;
      if (uo_out[0]) begin x_ack = 1'b1; x_ack_edge = n; break; end
    end
    x_rdata = uio_out; x_err = uo_out[2]; x_rw = uo_out[3]; x_oe = uio_oe;
    for (int n = 0; n < hold; n++) begin
      @(posedge clk); #1;
      if (!uo_out[0]) x_held = 1'b0;
    end
    @(negedge clk);
    ui_in[0] = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (!uo_out[0] && uio_oe == 8'h00) begin x_rel_edge = n; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (uo_out !== 8'h00 || uio_oe !== 8'h00 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: uo_out=%h uio_oe=%h uio_out=%h expected all 00", uo_out, uio_oe, uio_out);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    for (int a = 0; a < NREGS; a++) begin
      xact(1'b0, 3'(a), 8'h00, 0);
      checks++;
      if (x_ack !== 1'b1 || x_rdata !== 8'h00 || x_err !== 1'b0 || x_oe !== 8'hFF || x_rel_edge < 0) begin
        errors++;
        $display("FAIL reset_read%0d: ack=%b data=%h err=%b oe=%h rel=%0d expected 1 00 0 ff >0",
                 a, x_ack, x_rdata, x_err, x_oe, x_rel_edge);
      end
    end
  endtask

  task automatic test_write_readback();
    xact(1'b1, 3'd2, 8'hA5, 0);
    model_write(3'd2, 8'hA5);
    checks++;
    if (x_ack !== 1'b1 || x_err !== 1'b0 || x_oe !== 8'h00 || x_ack_edge != SYNC + 2 || int'(uo_out[7:4]) != mcount) begin
      errors++;
      $display("FAIL write_a5: ack=%b err=%b oe=%h ack_edge=%0d count=%0d expected 1 0 00 %0d %0d",
               x_ack, x_err, x_oe, x_ack_edge, uo_out[7:4], SYNC + 2, mcount);
    end
    xact(1'b0, 3'd2, 8'h00, 0);
    checks++;
    if (x_rdata !== 8'hA5 || uo_out[7:4] !== 4'd1 || x_rw !== 1'b0) begin
      errors++;
      $display("FAIL readback_a5: data=%h count=%0d rw=%b expected a5 1 0", x_rdata, uo_out[7:4], x_rw);
    end
    checks++;
    if (x_oe_edge != SYNC + 1 || x_ack_edge != SYNC + 2 || x_rel_edge != SYNC + 1) begin
      errors++;
      $display("FAIL latency: oe_edge=%0d ack_edge=%0d rel_edge=%0d expected %0d %0d %0d",
               x_oe_edge, x_ack_edge, x_rel_edge, SYNC + 1, SYNC + 2, SYNC + 1);
    end
  endtask

  task automatic test_out_of_range();
    xact(1'b1, 3'd5, 8'h3C, 0);
    model_write(3'd5, 8'h3C);
    checks++;
    if (x_ack !== 1'b1 || x_err !== 1'b1 || int'(uo_out[7:4]) != mcount) begin
      errors++;
      $display("FAIL oor_write: ack=%b err=%b count=%0d expected 1 1 %0d", x_ack, x_err, uo_out[7:4], mcount);
    end
    xact(1'b0, 3'd5, 8'h00, 0);
    checks++;
    if (x_ack !== 1'b1 || x_err !== 1'b1 || x_rdata !== 8'hFF) begin
      errors++;
      $display("FAIL oor_read: ack=%b err=%b data=%h expected 1 1 ff", x_ack, x_err, x_rdata);
    end
    for (int a = 0; a < NREGS; a++) begin
      xact(1'b0, 3'(a), 8'h00, 0);
      checks++;
      if (x_rdata !== exp_read(3'(a)) || x_err !== 1'b0) begin
        errors++;
        $display("FAIL oor_intact%0d: data=%h err=%b expected %h 0", a, x_rdata, x_err, exp_read(3'(a)));
      end
    end
  endtask

  task automatic test_random();
    logic       rw;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom_range(0, 1));
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      exp = exp_read(a);
      xact(rw, a, d, 0);
      if (rw) model_write(a, d);
      checks++;
      if (x_ack !== 1'b1 || x_err !== (int'(a) >= NREGS) || x_rw !== rw || int'(uo_out[7:4]) != mcount ||
          (!rw && x_rdata !== exp) || (rw && x_oe !== 8'h00)) begin
        errors++;
        $display("FAIL random%0d: rw=%b addr=%0d ack=%b err=%b rwbit=%b data=%h oe=%h count=%0d expected data=%h count=%0d",
                 i, rw, a, x_ack, x_err, x_rw, x_rdata, x_oe, uo_out[7:4], exp, mcount);
      end
    end
  endtask

  task automatic test_counter_wrap();
    logic [2:0] a;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      a = 3'($urandom_range(0, NREGS - 1));
      d = 8'($urandom);
      xact(1'b1, a, d, 0);
      model_write(a, d);
    end
    checks++;
    if (uo_out[7:4] !== 4'd1 || mcount != 1) begin
      errors++;
      $display("FAIL count_wrap: count=%0d expected 1", uo_out[7:4]);
    end
    xact(1'b1, 3'd0, 8'hC3, 10);
    model_write(3'd0, 8'hC3);
    checks++;
    if (x_held !== 1'b1 || uo_out[7:4] !== 4'd2) begin
      errors++;
      $display("FAIL held_strobe: ack_held=%b count=%0d expected 1 2", x_held, uo_out[7:4]);
    end
    xact(1'b0, 3'd0, 8'h00, 0);
    checks++;
    if (x_rdata !== 8'hC3) begin
      errors++;
      $display("FAIL held_readback: data=%h expected c3", x_rdata);
    end
  endtask

  task automatic test_reset_mid_read();
    logic seen;
    logic got;
    xact(1'b1, 3'd1, 8'h5A, 0);
    model_write(3'd1, 8'h5A);
    @(negedge clk);
    ui_in = {3'b000, 3'd1, 1'b0, 1'b1};
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (uo_out[0]) begin got = 1'b1; break; end
    end
    checks++;
    if (got !== 1'b1 || uio_out !== 8'h5A) begin
      errors++;
      $display("FAIL midread_ack: ack=%b data=%h expected 1 5a", got, uio_out);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (uio_oe !== 8'h00 || uo_out !== 8'h00) begin
      errors++;
      $display("FAIL midread_reset: uio_oe=%h uo_out=%h expected 00 00", uio_oe, uo_out);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (uo_out[0] || uo_out[1] || uio_oe != 8'h00) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL held_after_reset: activity=%b expected 0", seen);
    end
    @(negedge clk);
    ui_in[0] = 1'b0;
    repeat (6) @(negedge clk);
    xact(1'b0, 3'd1, 8'h00, 0);
    checks++;
    if (x_ack !== 1'b1 || x_rdata !== exp_read(3'd1)) begin
      errors++;
      $display("FAIL midread_regs: ack=%b data=%h expected 1 %h", x_ack, x_rdata, exp_read(3'd1));
    end
  endtask

  task automatic test_ena_gating();
    logic seen;
    logic got;
    @(negedge clk);
    ena = 1'b0;
    ui_in = {3'b000, 3'd3, 1'b1, 1'b1};
    uio_in = 8'h77;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (uo_out[0] || uo_out[1]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL ena_low: activity=%b expected 0", seen);
    end
    @(negedge clk);
    ena = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (uo_out[0] || uo_out[1]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL ena_rise_held: activity=%b expected 0", seen);
    end
    @(negedge clk);
    ui_in[0] = 1'b0;
    repeat (6) @(negedge clk);
    ui_in = {3'b000, 3'd3, 1'b1, 1'b1};
    uio_in = 8'h99;
    repeat (SYNC + 1) @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (uo_out[0]) begin got = 1'b1; break; end
    end
    @(negedge clk);
    ui_in[0] = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (!uo_out[0]) break;
    end
    model_write(3'd3, 8'h99);
    checks++;
    if (got !== 1'b1 || int'(uo_out[7:4]) != mcount) begin
      errors++;
      $display("FAIL ena_drop_inflight: ack=%b count=%0d expected 1 %0d", got, uo_out[7:4], mcount);
    end
    @(negedge clk);
    ena = 1'b1;
    repeat (3) @(negedge clk);
    xact(1'b0, 3'd3, 8'h00, 0);
    checks++;
    if (x_rdata !== 8'h99) begin
      errors++;
      $display("FAIL ena_drop_readback: data=%h expected 99", x_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_out_of_range();
    test_random();
    test_counter_wrap();
    test_reset_mid_read();
    test_ena_gating();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uio_reg_responder.md
Name: uio_reg_responder

Overview:
Device-side responder for the parallel register-access protocol the host drives on the tile pins.
- Host side: ui_in carries strobe, direction and address; uio carries data in both directions.
- Block side: holds a small bank of 8-bit registers and runs a 4-phase strobe/ack handshake.
- Turns the uio bus around (uio_oe) for reads, and reports ack/error/status on uo_out.
- Sits directly under the top-level tt_um wrapper.

Parameters:
- NREGS, 4: number of 8-bit registers, 1..8.
- SYNC_STAGES, 2: flops in the strobe synchronizer, 2..3.
- RESET_VAL, 8'h00: reset value of every register.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  design selected; gates the start of new transactions.
- ui_in  in  8  [0]=strobe, [1]=rw (1 write, 0 read), [4:2]=addr, [7:5] ignored.
- uio_in  in  8  write data from host.
- uio_out  out  8  read data to host.
- uio_oe  out  8  8'hFF while driving read data, else 8'h00.
- uo_out  out  8  [0]=ack, [1]=busy, [2]=err, [3]=rw of last transaction, [7:4]=successful-write count.

Behaviour:
- Reset (rst=1 at an edge):
  - State IDLE; all registers = RESET_VAL; synchronizer and previous-strobe flop = 0.
  - uio_out=0, uio_oe=0, uo_out=0.
  - Mid-transaction reset drops uio_oe and ack at that same edge.
- Strobe path:
  - ui_in[0] passes through SYNC_STAGES flops to give strobe_s; a further flop gives strobe_p.
  - rw, addr and uio_in are sampled raw. Host holds them stable from strobe rise until ack is seen.
- FSM states IDLE, XFER, ACK.
- IDLE:
  - If ena & strobe_s & !strobe_p: capture rw/addr/data, then go to XFER.
  - A strobe already high on leaving reset, or when ena rises, is ignored until it falls and rises again.
- Entering XFER:
  - busy=1; err = (addr >= NREGS); uo_out[3] = rw.
  - Read: uio_out = reg[addr], or 8'hFF if err; uio_oe = 8'hFF.
- XFER -> ACK, unconditionally after one cycle:
  - Write with no err: reg[addr] <= data; write count +1, wrapping 15 -> 0.
  - Write with err: no register change, no count change.
  - ack=1.
- ACK:
  - Hold ack, busy and, for reads, the uio drive while strobe_s=1.
  - On strobe_s=0 go to IDLE: ack=0, busy=0, uio_oe=0, uio_out=0, all at that same edge.
- err and uo_out[3] persist after the transaction; both are overwritten on entry to the next XFER.
- ena dropping mid-transaction does not abort it; the transaction completes normally.
- Latency, counted in rising edges after the first edge that samples ui_in[0]=1:
  - uio_oe rises after SYNC_STAGES+1 edges.
  - ack rises after SYNC_STAGES+2 edges.
- Release: ack and uio_oe fall SYNC_STAGES+1 edges after the first edge that samples ui_in[0]=0.
- Back-to-back transactions:
  - Minimum strobe period is fixed by the handshake.
  - A new rise is recognised only in IDLE.
- uio_oe is never nonzero during a write or in IDLE, so there is no bus contention.

Test Plan:
- Reset then reads:
  - Stimulus: rst 2 cycles; read addr 0..3.
  - Required: each returns 8'h00; uio_oe=8'hFF only between XFER and release; err=0.
- Write then read back:
  - Stimulus: write 8'hA5 to addr 2, then read addr 2.
  - Required: read returns 8'hA5; uo_out[7:4]=1.
  - Required with SYNC_STAGES=2: ack rises exactly 4 edges after strobe is sampled high, and uio_oe rises 1 edge before ack.
- Out-of-range address:
  - Stimulus: write 8'h3C to addr 5, then read addr 5, with NREGS=4.
  - Required: both transactions ack with err=1; the read returns 8'hFF; registers 0..3 unchanged; write count unchanged.
- Counter wrap and held strobe:
  - Stimulus: 17 valid writes.
  - Required: uo_out[7:4]=1.
  - Stimulus: hold strobe high 10 cycles after ack.
  - Required: ack stays 1 and no second write occurs.
- Reset mid-read:
  - Stimulus: assert rst in the ACK state of a read of 8'h5A.
  - Required: the next edge gives uio_oe=0, ack=0, state IDLE, registers = RESET_VAL.
  - Required: strobe still high after rst release starts no transaction until it toggles low then high.
- ena gating:
  - Stimulus: ena=0, strobe rises.
  - Required: no ack within 20 cycles.
  - Stimulus: ena=1 while strobe is held high.
  - Required: still no transaction.
  - Stimulus: drop ena during an in-flight write.
  - Required: the write completes and ack is given.
